lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 122 ++++++++++++
 tb/tb_lsu_mem_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store unit bridging a core request/response
// channel to a byte-addressed RAM port with combinational read data.
package imhotep_pkg;
   localparam int XLEN      = 32;
   localparam int RAM_WIDTH = 12;
endpackage

module lsu_mem_port
   import imhotep_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_store_i,
   input  logic [2:0]           req_funct3_i,
   input  logic [XLEN-1:0]      req_addr_i,
   input  logic [XLEN-1:0]      req_wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [XLEN-1:0]      rsp_rdata_o,
   output logic                 rsp_misalign_o,
   output logic                 rsp_fault_o,
   output logic                 ram_w_rn_o,
   output logic [1:0]           ram_width_o,
   output logic [RAM_WIDTH-1:0] ram_addr_o,
   output logic [XLEN-1:0]      ram_data_o,
   input  logic [XLEN-1:0]      ram_data_i
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t               state_q, state_d;
   logic                 store_q, store_d;
   logic [2:0]           funct3_q, funct3_d;
   logic [RAM_WIDTH-1:0] addr_q, addr_d;
   logic [XLEN-1:0]      wdata_q, wdata_d;
   logic [XLEN-1:0]      rdata_q, rdata_d;
   logic                 misalign_q, misalign_d;
   logic                 fault_q, fault_d;
   logic                 f3_legal, req_mis, req_flt;
   logic [XLEN-1:0]      ld_ext;

   assign req_ready_o = (state_q == IDLE) & ~reset;

   // BU/HU only exist as loads; a store with those encodings is a fault
   always_comb begin
      f3_legal = (req_funct3_i inside {3'b000, 3'b001, 3'b010}) |
                 (~req_store_i & (req_funct3_i inside {3'b100, 3'b101}));
      req_mis  = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                 ((req_funct3_i == 3'b010) & (|req_addr_i[1:0]));
      req_flt  = ~f3_legal | (|req_addr_i[XLEN-1:RAM_WIDTH]);
   end

   always_comb begin
      ld_ext = (funct3_q == 3'b000) ? {{(XLEN-8){ram_data_i[7]}}, ram_data_i[7:0]} :
               (funct3_q == 3'b100) ? {{(XLEN-8){1'b0}}, ram_data_i[7:0]} :
               (funct3_q == 3'b001) ? {{(XLEN-16){ram_data_i[15]}}, ram_data_i[15:0]} :
               (funct3_q == 3'b101) ? {{(XLEN-16){1'b0}}, ram_data_i[15:0]} :
               ram_data_i;
   end

   always_comb begin
      state_d    = state_q;
      store_d    = store_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      fault_d    = fault_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i & req_ready_o) begin
               store_d    = req_store_i;
               funct3_d   = req_funct3_i;
               addr_d     = req_addr_i[RAM_WIDTH-1:0];
               wdata_d    = req_wdata_i;
               rdata_d    = '0;
               misalign_d = req_mis;
               fault_d    = req_flt;
               state_d    = (req_mis | req_flt) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            rdata_d = store_q ? '0 : ld_ext;
            state_d = RESP;
         end
         RESP: state_d = rsp_ready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         store_q    <= 1'b0;
         funct3_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         store_q    <= store_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         fault_q    <= fault_d;
      end
   end

   assign rsp_valid_o    = (state_q == RESP);
   assign rsp_rdata_o    = rdata_q;
   assign rsp_misalign_o = misalign_q;
   assign rsp_fault_o    = fault_q;
   assign ram_w_rn_o     = (state_q == ACCESS) & store_q;
   assign ram_width_o    = funct3_q[1:0];
   assign ram_addr_o     = addr_q;
   assign ram_data_o     = wdata_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed stimulus against a request-level model of the load/store unit,
// with a per-cycle compare process and hand-computed literal expectations.
module tb_lsu_mem_port;
   localparam int AW = imhotep_pkg::RAM_WIDTH;
   localparam int XW = imhotep_pkg::XLEN;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid_i, req_ready_o, req_store_i;
   logic [2:0]    req_funct3_i;
   logic [XW-1:0] req_addr_i, req_wdata_i;
   logic          rsp_valid_o, rsp_ready_i;
   logic [XW-1:0] rsp_rdata_o;
   logic          rsp_misalign_o, rsp_fault_o;
   logic          ram_w_rn_o;
   logic [1:0]    ram_width_o;
   logic [AW-1:0] ram_addr_o;
   logic [XW-1:0] ram_data_o, ram_data_i;

   lsu_mem_port dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_misalign_o(rsp_misalign_o), .rsp_fault_o(rsp_fault_o),
      .ram_w_rn_o(ram_w_rn_o), .ram_width_o(ram_width_o), .ram_addr_o(ram_addr_o),
      .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM peripheral driven by the DUT's RAM port
   logic [7:0]  ram [0:(1<<AW)-1];
   logic [31:0] rword;
   always @(posedge clk) begin
      if (ram_w_rn_o) begin
         ram[ram_addr_o] <= ram_data_o[7:0];
         if (ram_width_o != 2'b00) ram[ram_addr_o + 12'd1] <= ram_data_o[15:8];
         if (ram_width_o == 2'b10) begin
            ram[ram_addr_o + 12'd2] <= ram_data_o[23:16];
            ram[ram_addr_o + 12'd3] <= ram_data_o[31:24];
         end
      end
   end
   always_comb begin
      rword = {ram[ram_addr_o + 12'd3], ram[ram_addr_o + 12'd2], ram[ram_addr_o + 12'd1], ram[ram_addr_o]};
      ram_data_i = (ram_width_o == 2'b00) ? {24'b0, rword[7:0]} :
                   (ram_width_o == 2'b01) ? {16'b0, rword[15:0]} : rword;
   end

   // model memory and outstanding-request scoreboard
   logic [7:0] mm [0:(1<<AW)-1];
   typedef struct {
      int          n;
      int          due;
      logic        st;
      logic        err;
      logic        mis;
      logic        flt;
      logic [2:0]  f3;
      logic [AW-1:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
   } exp_t;
   exp_t exp_q[$];
   logic [AW-1:0] last_a  = '0;
   logic [2:0]    last_f3 = '0;
   logic [31:0]   last_wd = '0;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      else pass_cnt++;
   endtask

   function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b100:  return {24'b0, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b101:  return {16'b0, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = mm[a + AW'(i)];
      return w;
   endfunction

   task automatic model_write(input logic [AW-1:0] a, input logic [2:0] f3, input logic [31:0] wd);
      int nb;
      nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      for (int i = 0; i < nb; i++) mm[a + AW'(i)] = wd[8*i +: 8];
   endtask

   function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
      return ((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
   endfunction

   function automatic logic model_flt(input logic st, input logic [2:0] f3, input logic [31:0] a);
      logic legal;
      legal = st ? (f3 <= 3'b010) : (f3 <= 3'b010 || f3 == 3'b100 || f3 == 3'b101);
      return !legal || (a >= 32'(1 << AW));
   endfunction

   // per-cycle compare against the scoreboard head
   logic ev, er, ew;
   always @(negedge clk) begin
      if (reset) begin
         ev = 1'b0; er = 1'b0; ew = 1'b0;
      end else if (exp_q.size() == 0) begin
         ev = 1'b0; er = 1'b1; ew = 1'b0;
      end else begin
         ev = (cyc >= exp_q[0].due);
         er = 1'b0;
         ew = !exp_q[0].err && exp_q[0].st && (cyc == exp_q[0].n);
      end
      chk("rsp_valid", rsp_valid_o, ev);
      chk("req_ready", req_ready_o, er);
      chk("ram_w_rn", ram_w_rn_o, ew);
      chk("ram_addr", ram_addr_o, last_a);
      chk("ram_width", ram_width_o, last_f3[1:0]);
      chk("ram_data", ram_data_o, last_wd);
      if (ev) begin
         chk("rsp_rdata", rsp_rdata_o, exp_q[0].rd);
         chk("rsp_misalign", rsp_misalign_o, exp_q[0].mis);
         chk("rsp_fault", rsp_fault_o, exp_q[0].flt);
      end
   end

   // issue one request from posedge+1; returns the response fields seen in RESP
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold, input bit abort,
                         output logic [31:0] rd, output logic mis, output logic flt);
      exp_t e;
      int k;
      req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
      rsp_ready_i = (hold == 0);
      @(posedge clk); #1;
      e.n   = cyc;
      e.st  = st;
      e.f3  = f3;
      e.a   = a[AW-1:0];
      e.wd  = wd;
      e.mis = model_mis(f3, a);
      e.flt = model_flt(st, f3, a);
      e.err = e.mis | e.flt;
      e.due = e.n + (e.err ? 0 : 1);
      e.rd  = (st || e.err) ? 32'h0 : ext(f3, model_read(e.a));
      exp_q.push_back(e);
      last_a = e.a; last_f3 = f3; last_wd = wd;
      rd = '0; mis = 1'b0; flt = 1'b0;
      if (hold > 0) begin
         req_addr_i  = a ^ 32'h4;
         req_wdata_i = ~wd;
      end else req_valid_i = 1'b0;
      if (abort) begin
         chk("abort_in_access", ram_w_rn_o, 1'b1);
         #1 reset = 1'b1;
         exp_q.delete();
         last_a = '0; last_f3 = '0; last_wd = '0;
         rsp_ready_i = 1'b0;
         #1;
         chk("abort_w_rn", ram_w_rn_o, 1'b0);
         chk("abort_valid", rsp_valid_o, 1'b0);
         chk("abort_ready", req_ready_o, 1'b0);
         @(posedge clk); #1 reset = 1'b0;
         @(posedge clk); #1;
         return;
      end
      k = 0;
      while (cyc < e.due && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      rd = rsp_rdata_o; mis = rsp_misalign_o; flt = rsp_fault_o;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      void'(exp_q.pop_front());
      if (st && !e.err) model_write(e.a, f3, wd);
   endtask

   logic [31:0] rd;
   logic        mis, flt;
   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = 8'h00;
         mm[i]  = 8'h00;
      end
      reset = 1'b1;
      req_valid_i = 1'b0; req_store_i = 1'b0; req_funct3_i = '0;
      req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready_o, 1'b0);
      chk("rst_valid", rsp_valid_o, 1'b0);
      chk("rst_w_rn", ram_w_rn_o, 1'b0);
      chk("rst_addr", ram_addr_o, '0);
      chk("rst_rdata", rsp_rdata_o, '0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", req_ready_o, 1'b1);
      chk("model_lb", ext(3'b000, 32'h00000080), 32'hFFFFFF80);
      chk("model_lhu", ext(3'b101, 32'h12348000), 32'h00008000);

      do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, rd, mis, flt);
      chk("sw_x10_err", {mis, flt}, 2'b00);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, 0, rd, mis, flt);
      chk("lw_x10", rd, 32'hDEADBEEF);
      chk("lw_x10_err", {mis, flt}, 2'b00);

      do_req(1, 3'b000, 32'h21, 32'h00000080, 0, 0, rd, mis, flt);
      do_req(0, 3'b000, 32'h21, 32'h0, 0, 0, rd, mis, flt);
      chk("lb_x21", rd, 32'hFFFFFF80);
      do_req(0, 3'b100, 32'h21, 32'h0, 0, 0, rd, mis, flt);
      chk("lbu_x21", rd, 32'h00000080);
      do_req(0, 3'b001, 32'h20, 32'h0, 0, 0, rd, mis, flt);
      chk("lh_x20", rd, 32'hFFFF8000);
      do_req(0, 3'b101, 32'h20, 32'h0, 0, 0, rd, mis, flt);
      chk("lhu_x20", rd, 32'h00008000);

      do_req(0, 3'b010, 32'h13, 32'h0, 0, 0, rd, mis, flt);
      chk("lw_x13_flags", {mis, flt}, 2'b10);
      chk("lw_x13_rdata", rd, 32'h0);

      do_req(1, 3'b011, 32'h10, 32'h12345678, 0, 0, rd, mis, flt);
      chk("sw_f3_011_flags", {mis, flt}, 2'b01);
      do_req(0, 3'b010, 32'h1000, 32'h0, 0, 0, rd, mis, flt);
      chk("lw_oob_flags", {mis, flt}, 2'b01);
      chk("lw_oob_rdata", rd, 32'h0);
      do_req(1, 3'b010, 32'h1010, 32'h55555555, 0, 0, rd, mis, flt);
      chk("sw_oob_flags", {mis, flt}, 2'b01);
      do_req(1, 3'b010, 32'h1001, 32'h66666666, 0, 0, rd, mis, flt);
      chk("sw_both_flags", {mis, flt}, 2'b11);
      do_req(1, 3'b100, 32'h20, 32'h77777777, 0, 0, rd, mis, flt);
      chk("sbu_store_flags", {mis, flt}, 2'b01);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, 0, rd, mis, flt);
      chk("lw_x10_unchanged", rd, 32'hDEADBEEF);

      do_req(0, 3'b010, 32'h10, 32'h0, 5, 0, rd, mis, flt);
      chk("lw_stall", rd, 32'hDEADBEEF);

      do_req(0, 3'b000, 32'hFFF, 32'h0, 0, 0, rd, mis, flt);
      chk("lb_xfff_empty", rd, 32'h0);
      do_req(1, 3'b010, 32'hFFC, 32'hA5A55A5A, 0, 0, rd, mis, flt);
      do_req(0, 3'b010, 32'hFFC, 32'h0, 0, 0, rd, mis, flt);
      chk("lw_xffc", rd, 32'hA5A55A5A);
      do_req(0, 3'b000, 32'hFFF, 32'h0, 0, 0, rd, mis, flt);
      chk("lb_xfff", rd, 32'hFFFFFFA5);
      do_req(0, 3'b010, 32'hFFF, 32'h0, 0, 0, rd, mis, flt);
      chk("lw_xfff_flags", {mis, flt}, 2'b10);

      do_req(1, 3'b001, 32'h30, 32'h12347FFF, 0, 0, rd, mis, flt);
      do_req(0, 3'b001, 32'h30, 32'h0, 0, 0, rd, mis, flt);
      chk("lh_x30_pos", rd, 32'h00007FFF);
      do_req(1, 3'b001, 32'h31, 32'h0, 0, 0, rd, mis, flt);
      chk("sh_x31_flags", {mis, flt}, 2'b10);

      do_req(1, 3'b010, 32'h40, 32'h11223344, 0, 0, rd, mis, flt);
      do_req(1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 1, rd, mis, flt);
      chk("post_abort_ready", req_ready_o, 1'b1);
      do_req(0, 3'b010, 32'h40, 32'h0, 0, 0, rd, mis, flt);
      chk("lw_x40_after_abort", rd, 32'h11223344);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
